umi_demux: RTL and testbench
============================

Name: umi_demux

Overview:
- Routes one incoming UMI stream to one of N outgoing UMI streams. This is the fan-out counterpart of the one-hot UMI mux.
- The target port is decoded from an index field in the packet's dstaddr.
- Each output port has a one-entry registered buffer, which gives a registered output and full throughput.
- Packets whose index field is N or greater are consumed, discarded and counted.
- Sits between a fabric link and N endpoints or sub-fabrics.

Parameters:
- DW, 256, UMI data width.
- CW, 32, UMI command width.
- AW, 64, UMI address width.
- N, 4, number of output ports; N >= 2.
- SELLSB, 40, LSB position of the port-index field in dstaddr. Requires SELLSB + SW <= AW.
- SW (localparam) = $clog2(N), port-index field width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- umi_in_valid  input  1  input packet valid.
- umi_in_cmd  input  CW  input command.
- umi_in_dstaddr  input  AW  input destination address.
- umi_in_srcaddr  input  AW  input source address.
- umi_in_data  input  DW  input data.
- umi_in_ready  output  1  input accept.
- umi_out_valid  output  N  per-port valid.
- umi_out_ready  input  N  per-port ready.
- umi_out_cmd  output  N*CW  per-port command; port i at [i*CW +: CW].
- umi_out_dstaddr  output  N*AW  per-port dstaddr.
- umi_out_srcaddr  output  N*AW  per-port srcaddr.
- umi_out_data  output  N*DW  per-port data.
- drop_count  output  16  saturating count of discarded packets.

Behaviour:
- Clock and reset: single clock clk; nreset is asynchronous and active-low.
- Reset: when nreset is low, immediately clear all umi_out_valid, all umi_out_cmd/dstaddr/srcaddr/data fields and drop_count to 0. Clearing is asynchronous. The first accept can occur on the first rising edge after nreset goes high.
- Decode:
  - sel = umi_in_dstaddr[SELLSB +: SW].
  - sel < N selects port sel.
  - sel >= N is out of range; this is only possible when N is not a power of 2.
  - dstaddr is forwarded unmodified; the index bits are not stripped.
- Per-port buffer state: buf_valid[i], which drives umi_out_valid[i], and the registered packet fields.
- Port drain: drain[i] = buf_valid[i] & umi_out_ready[i].
- Input ready:
  - In range: umi_in_ready = ~buf_valid[sel] | umi_out_ready[sel].
  - Out of range: umi_in_ready = 1.
  - umi_in_ready does not depend on umi_in_valid.
  - It depends combinationally only on dstaddr, buf_valid and umi_out_ready.
- Accept: acc = umi_in_valid & umi_in_ready.
- In-range accept into port p:
  - On the next edge, load the fields into buffer p and set buf_valid[p]=1.
  - Latency from accept to umi_out_valid[p] is exactly 1 cycle.
- Simultaneous drain and accept on the same port: buffer reloads and buf_valid stays 1. This sustains 1 packet/cycle per port.
- Drain without accept: buf_valid[i] clears on the next edge.
- Ports other than p are unaffected by the accept. They drain independently, so several ports may present valid simultaneously.
- Out-of-range accept: the packet is discarded; no umi_out_valid rises. drop_count increments by 1 and saturates at 16'hFFFF.
- Valid rule: umi_out_valid[i], once high, stays high with stable fields until umi_out_ready[i] is sampled high.
- Ordering: packets to the same port leave in arrival order. There is no ordering guarantee across ports.
- Idle fields: fields of a port whose buffer is empty hold their last value (0 after reset). No X propagation.
- umi_in_valid low: no state change except drains.
- Storage: one register set per port. No other storage; no internal combinational valid-to-valid path.

Test Plan:
1. Reset with nreset=0, then release; any in-range dstaddr -> umi_out_valid=4'b0000, drop_count=0, umi_in_ready=1.
2. One packet with dstaddr[41:40]=2, cmd=32'h0000_0013, data=256'hA5 (one packet), all umi_out_ready=1 -> umi_out_valid=4'b0100 exactly 1 cycle after accept; port-2 cmd, dstaddr, srcaddr and data equal the input. Valid drops the following cycle.
3. Backpressure: umi_out_ready[1]=0; two packets to port 1 -> first accepted, second sees umi_in_ready=0. A concurrent packet to port 0 is also held off because the input is blocked at the head. Raise umi_out_ready[1]=1 -> first drains, second is accepted the same cycle and appears next cycle.
4. Streaming: 8 back-to-back packets to port 3 with data=0..7, umi_out_ready[3]=1 -> umi_in_ready stays 1. Port 3 outputs data 0..7 on 8 consecutive cycles with no bubbles.
5. Drop, with N=3: packet with index field 3 -> accepted (umi_in_ready=1), umi_out_valid stays 3'b000, drop_count=1. Force the counter to 16'hFFFF and drop another packet -> drop_count stays 16'hFFFF.
6. Reset mid-operation: port 2 full with umi_out_ready[2]=0 and drop_count=5; pulse nreset low between edges -> umi_out_valid=0 and drop_count=0 immediately, before the next clk edge. Normal traffic resumes after release.

Source files
------------

// File: rtl/umi_demux_if.sv
// umi_demux_if: bundle of the single UMI input stream, the N output streams and the drop counter
interface umi_demux_if #(
  parameter int DW = 256,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int N  = 4
);
  logic            umi_in_valid;
  logic [CW-1:0]   umi_in_cmd;
  logic [AW-1:0]   umi_in_dstaddr;
  logic [AW-1:0]   umi_in_srcaddr;
  logic [DW-1:0]   umi_in_data;
  logic            umi_in_ready;
  logic [N-1:0]    umi_out_valid;
  logic [N-1:0]    umi_out_ready;
  logic [N*CW-1:0] umi_out_cmd;
  logic [N*AW-1:0] umi_out_dstaddr;
  logic [N*AW-1:0] umi_out_srcaddr;
  logic [N*DW-1:0] umi_out_data;
  logic [15:0]     drop_count;
  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data, umi_out_ready,
    input  umi_in_ready, umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data, drop_count
  );
  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data, umi_out_ready,
    output umi_in_ready, umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data, drop_count
  );
endinterface

// File: rtl/umi_demux.sv
// umi_demux: routes one UMI stream to one of N ports selected by a dstaddr index field, one registered slot per port
module umi_demux #(
  parameter int DW     = 256,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int N      = 4,
  parameter int SELLSB = 40
) (
  input logic         clk,
  input logic         nreset,
  umi_demux_if.slave  io_umi
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] w_sel;
  logic          w_inrange;
  logic          w_busy;
  logic          w_acc;
  logic [N-1:0]  w_drain;
  logic [N-1:0]  w_load;
  logic [N-1:0]  r_valid;
  logic [CW-1:0] r_cmd [N];
  logic [AW-1:0] r_dst [N];
  logic [AW-1:0] r_src [N];
  logic [DW-1:0] r_data [N];
  logic [15:0]   r_drop;
  assign w_sel     = io_umi.umi_in_dstaddr[SELLSB +: SW];
  assign w_inrange = 32'(w_sel) < N;
  assign w_busy    = w_inrange ? (r_valid[w_sel] & ~io_umi.umi_out_ready[w_sel]) : 1'b0;
  assign w_acc     = io_umi.umi_in_valid & ~w_busy;
  assign w_drain   = r_valid & io_umi.umi_out_ready;
  assign io_umi.umi_in_ready  = ~w_busy;
  assign io_umi.umi_out_valid = r_valid;
  assign io_umi.drop_count    = r_drop;
  // one-hot load strobe for the port addressed by an accepted in-range packet
  always_comb begin
    w_load = '0;
    for (int i = 0; i < N; i++) w_load[i] = w_acc & w_inrange & (32'(w_sel) == i);
  end
  // per-port slot: reload on accept (even while draining), clear valid on drain alone
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_valid <= '0;
      for (int i = 0; i < N; i++) begin
        r_cmd[i]  <= '0;
        r_dst[i]  <= '0;
        r_src[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_cmd[i]   <= io_umi.umi_in_cmd;
          r_dst[i]   <= io_umi.umi_in_dstaddr;
          r_src[i]   <= io_umi.umi_in_srcaddr;
          r_data[i]  <= io_umi.umi_in_data;
        end else if (w_drain[i]) r_valid[i] <= 1'b0;
      end
    end
  // saturating count of packets whose index field names no port
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) r_drop <= '0;
    else if (w_acc & ~w_inrange & ~&r_drop) r_drop <= r_drop + 16'd1;
  for (genvar g = 0; g < N; g++) begin : g_out
    assign io_umi.umi_out_cmd[g*CW +: CW]     = r_cmd[g];
    assign io_umi.umi_out_dstaddr[g*AW +: AW] = r_dst[g];
    assign io_umi.umi_out_srcaddr[g*AW +: AW] = r_src[g];
    assign io_umi.umi_out_data[g*DW +: DW]    = r_data[g];
  end
endmodule

// File: tb/tb_umi_demux.sv
// tb_umi_demux: drives a 4-port and a 3-port demux with the same stream and checks both against per-port queue models
module tb_umi_demux;
  typedef struct packed {
    logic [31:0]  c;
    logic [63:0]  d;
    logic [63:0]  s;
    logic [255:0] x;
  } pkt_t;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic iv = 1'b0;
  logic [31:0] ic = '0;
  logic [63:0] idst = '0;
  logic [63:0] isrc = '0;
  logic [255:0] idat = '0;
  logic [3:0] rdy = 4'hF;
  int vec = 0;
  int miss = 0;
  pkt_t q [8][$];
  pkt_t lastp [8];
  int mdrop [2];
  always #5 clk = ~clk;
  umi_demux_if #(.N(4)) ifa ();
  umi_demux_if #(.N(3)) ifb ();
  umi_demux #(.N(4)) dut4 (.clk(clk), .nreset(nreset), .io_umi(ifa));
  umi_demux #(.N(3)) dut3 (.clk(clk), .nreset(nreset), .io_umi(ifb));
  assign ifa.umi_in_valid = iv;
  assign ifa.umi_in_cmd = ic;
  assign ifa.umi_in_dstaddr = idst;
  assign ifa.umi_in_srcaddr = isrc;
  assign ifa.umi_in_data = idat;
  assign ifa.umi_out_ready = rdy;
  assign ifb.umi_in_valid = iv;
  assign ifb.umi_in_cmd = ic;
  assign ifb.umi_in_dstaddr = idst;
  assign ifb.umi_in_srcaddr = isrc;
  assign ifb.umi_in_data = idat;
  assign ifb.umi_out_ready = rdy[2:0];
  task automatic cmp(input string tag, input logic [255:0] o, input logic [255:0] e);
    vec++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic int np(input int d);
    return d == 0 ? 4 : 3;
  endfunction
  function automatic bit m_ready(input int d);
    int s = int'(idst[41:40]);
    if (s >= np(d)) return 1'b1;
    return q[d*4+s].size() == 0 || rdy[s];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      q[i].delete();
      lastp[i] = '0;
    end
    mdrop[0] = 0;
    mdrop[1] = 0;
  endtask
  task automatic m_edge();
    pkt_t pk = {ic, idst, isrc, idat};
    int s = int'(idst[41:40]);
    for (int d = 0; d < 2; d++) begin
      bit a = bit'(iv) && m_ready(d);
      for (int p = 0; p < np(d); p++)
        if (q[d*4+p].size() != 0 && rdy[p]) void'(q[d*4+p].pop_front());
      if (a) begin
        if (s < np(d)) begin
          q[d*4+s].push_back(pk);
          lastp[d*4+s] = pk;
        end else if (mdrop[d] < 65535) mdrop[d]++;
      end
    end
  endtask
  task automatic chk();
    logic [3:0] ov;
    logic [127:0] oc;
    logic [255:0] od, os;
    logic [1023:0] ox;
    logic [15:0] dc;
    logic rd;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ov = ifa.umi_out_valid; oc = ifa.umi_out_cmd; od = ifa.umi_out_dstaddr;
        os = ifa.umi_out_srcaddr; ox = ifa.umi_out_data; dc = ifa.drop_count; rd = ifa.umi_in_ready;
      end else begin
        ov = 4'(ifb.umi_out_valid); oc = 128'(ifb.umi_out_cmd); od = 256'(ifb.umi_out_dstaddr);
        os = 256'(ifb.umi_out_srcaddr); ox = 1024'(ifb.umi_out_data); dc = ifb.drop_count; rd = ifb.umi_in_ready;
      end
      cmp($sformatf("n%0d in_ready", np(d)), 256'(rd), 256'(m_ready(d)));
      cmp($sformatf("n%0d drop_count", np(d)), 256'(dc), 256'(mdrop[d]));
      for (int p = 0; p < np(d); p++) begin
        cmp($sformatf("n%0d p%0d valid", np(d), p), 256'(ov[p]), 256'(q[d*4+p].size() != 0));
        cmp($sformatf("n%0d p%0d cmd", np(d), p), 256'(oc[p*32 +: 32]), 256'(lastp[d*4+p].c));
        cmp($sformatf("n%0d p%0d dst", np(d), p), 256'(od[p*64 +: 64]), 256'(lastp[d*4+p].d));
        cmp($sformatf("n%0d p%0d src", np(d), p), 256'(os[p*64 +: 64]), 256'(lastp[d*4+p].s));
        cmp($sformatf("n%0d p%0d data", np(d), p), ox[p*256 +: 256], lastp[d*4+p].x);
      end
    end
  endtask
  task automatic step();
    #1 chk();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask
  task automatic step_fast();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask
  task automatic send(input int port, input logic [255:0] data);
    iv = 1'b1;
    ic = $urandom;
    idst = {$urandom, $urandom};
    idst[41:40] = 2'(port);
    isrc = {$urandom, $urandom};
    idat = data;
  endtask
  task automatic do_reset();
    iv = 1'b0;
    nreset = 1'b0;
    #2;
    m_reset();
    chk();
    nreset = 1'b1;
    step();
  endtask
  initial begin
    m_reset();
    @(negedge clk);
    do_reset();
    idst = 64'h0000_0100_0000_0000;
    #1;
    cmp("t1 ready", 256'(ifa.umi_in_ready), 256'(1));
    cmp("t1 valid", 256'(ifa.umi_out_valid), 256'(0));
    cmp("t1 drop", 256'(ifa.drop_count), 256'(0));
    @(negedge clk);
    rdy = 4'hF;
    send(2, 256'hA5);
    ic = 32'h0000_0013;
    step();
    iv = 1'b0;
    cmp("t2 valid", 256'(ifa.umi_out_valid), 256'(4'b0100));
    cmp("t2 cmd", 256'(ifa.umi_out_cmd[2*32 +: 32]), 256'(32'h13));
    cmp("t2 dst", 256'(ifa.umi_out_dstaddr[2*64 +: 64]), 256'(idst));
    cmp("t2 src", 256'(ifa.umi_out_srcaddr[2*64 +: 64]), 256'(isrc));
    cmp("t2 data", ifa.umi_out_data[2*256 +: 256], 256'hA5);
    step();
    cmp("t2 drop valid", 256'(ifa.umi_out_valid), 256'(0));
    rdy = 4'b1101;
    send(1, 256'hA);
    step();
    send(1, 256'hB);
    step();
    cmp("t3 blocked ready", 256'(ifa.umi_in_ready), 256'(0));
    cmp("t3 held valid", 256'(ifa.umi_out_valid), 256'(4'b0010));
    step();
    cmp("t3 port0 held off", 256'(ifa.umi_out_valid[0]), 256'(0));
    cmp("t3 first still held", ifa.umi_out_data[1*256 +: 256], 256'hA);
    rdy = 4'hF;
    step();
    cmp("t3 second valid", 256'(ifa.umi_out_valid), 256'(4'b0010));
    cmp("t3 second data", ifa.umi_out_data[1*256 +: 256], 256'hB);
    send(0, 256'hC);
    step();
    cmp("t3 port0 valid", 256'(ifa.umi_out_valid), 256'(4'b0001));
    cmp("t3 port0 data", ifa.umi_out_data[0 +: 256], 256'hC);
    iv = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      send(3, 256'(i));
      #1 cmp("t4 ready", 256'(ifa.umi_in_ready), 256'(1));
      step();
      cmp("t4 valid", 256'(ifa.umi_out_valid[3]), 256'(1));
      cmp("t4 data", ifa.umi_out_data[3*256 +: 256], 256'(i));
    end
    iv = 1'b0;
    step();
    for (int k = 0; k < 3000; k++) begin
      send(int'($urandom_range(0, 3)), {8{$urandom}});
      iv = ($urandom_range(0, 3) != 0);
      rdy = 4'($urandom);
      step();
    end
    do_reset();
    rdy = 4'hF;
    send(3, 256'h77);
    #1 cmp("t5 ready", 256'(ifb.umi_in_ready), 256'(1));
    step();
    cmp("t5 valid", 256'(ifb.umi_out_valid), 256'(0));
    cmp("t5 drop1", 256'(ifb.drop_count), 256'(1));
    for (int k = 0; k < 65533; k++) step_fast();
    cmp("t5 drop fffe", 256'(ifb.drop_count), 256'(16'hFFFE));
    step();
    cmp("t5 drop ffff", 256'(ifb.drop_count), 256'(16'hFFFF));
    step();
    cmp("t5 drop sat", 256'(ifb.drop_count), 256'(16'hFFFF));
    do_reset();
    rdy = 4'b1011;
    send(3, 256'h5);
    for (int k = 0; k < 5; k++) step();
    send(2, 256'h22);
    step();
    iv = 1'b0;
    step();
    cmp("t6 port2 full", 256'(ifb.umi_out_valid), 256'(3'b100));
    cmp("t6 drop5", 256'(ifb.drop_count), 256'(5));
    nreset = 1'b0;
    #1;
    m_reset();
    cmp("t6 async valid", 256'(ifb.umi_out_valid), 256'(0));
    cmp("t6 async drop", 256'(ifb.drop_count), 256'(0));
    cmp("t6 async data", ifb.umi_out_data[2*256 +: 256], 256'(0));
    chk();
    #1 nreset = 1'b1;
    step();
    rdy = 4'hF;
    send(0, 256'h99);
    step();
    iv = 1'b0;
    cmp("t6 resume valid", 256'(ifb.umi_out_valid), 256'(3'b001));
    cmp("t6 resume data", ifb.umi_out_data[0 +: 256], 256'h99);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
